// File: rtl/cpu_core.sv
// ---------------------------------------------------------------------------
// cpu_core -- 16-bit multicycle core, eight registers R0..R7, 16-bit PC.
//
// Every instruction is fetched in FETCH and decoded/executed in EXEC. LW and
// SW spend one more cycle in MEM, where they make exactly one data access.
// Non-memory instructions take 2 cycles; LW and SW take 3.
//
// Ports
//   clk, rst              system clock, synchronous active-high reset
//   clk_50MHz, clk_11MHz  board clocks, accepted and unused
//   ram1_data/addr        shared data-RAM / UART bus (16b inout, 18b addr)
//   ram1_en/oe/we         RAM1 strobes, active-low
//   ram2_data/addr        instruction bus (read-only) and {2'b00, PC}
//   ram2_en/oe/we         RAM2 strobes, active-low, ram2_we tied high
//   tsre, tbre            UART transmit shift / transmit buffer empty
//   data_ready            UART receive data available
//   rdn, wrn              UART read / write strobes, active-low
//
// Data map: 0xBF00 is the UART data port, 0xBF01 the UART status port,
// everything else is RAM1 at {2'b00, addr}.
// ---------------------------------------------------------------------------
module cpu_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_50MHz,
    input  logic        clk_11MHz,
    inout  wire  [15:0] ram1_data,
    output logic [17:0] ram1_addr,
    output logic        ram1_en,
    output logic        ram1_oe,
    output logic        ram1_we,
    inout  wire  [15:0] ram2_data,
    output logic [17:0] ram2_addr,
    output logic        ram2_en,
    output logic        ram2_oe,
    output logic        ram2_we,
    input  logic        tsre,
    input  logic        tbre,
    input  logic        data_ready,
    output logic        rdn,
    output logic        wrn
);

    typedef enum logic [1:0] {FETCH, EXEC, MEM} state_t;

    localparam logic [15:0] NOP_IR    = 16'h0800;
    localparam logic [15:0] UART_DATA = 16'hBF00;
    localparam logic [15:0] UART_STAT = 16'hBF01;

    localparam logic [4:0] OP_NOP   = 5'b00001;
    localparam logic [4:0] OP_B     = 5'b00010;
    localparam logic [4:0] OP_BEQZ  = 5'b00100;
    localparam logic [4:0] OP_BNEZ  = 5'b00101;
    localparam logic [4:0] OP_ADDIU = 5'b01001;
    localparam logic [4:0] OP_LI    = 5'b01101;
    localparam logic [4:0] OP_LW    = 5'b10011;
    localparam logic [4:0] OP_SW    = 5'b11011;
    localparam logic [4:0] OP_RRR   = 5'b11100;
    localparam logic [4:0] OP_RR    = 5'b11101;

    // The board clocks are not used by any logic.
    logic unused_clks;
    assign unused_clks = clk_50MHz ^ clk_11MHz;

    state_t      state, state_nxt;
    logic [15:0] pc;
    logic [15:0] ir;
    logic [15:0] mem_addr;
    logic [15:0] regs [8];

    // ---------------------------------------------------------------------
    // Instruction fields
    // ---------------------------------------------------------------------
    logic [4:0]  opcode;
    logic [2:0]  rx, ry, rz;
    logic [15:0] rx_val, ry_val;
    logic [15:0] imm8_z, imm8_s, imm5_s, imm11_s;
    logic [15:0] pc_inc;
    logic        is_load, is_store;

    assign opcode   = ir[15:11];
    assign rx       = ir[10:8];
    assign ry       = ir[7:5];
    assign rz       = ir[4:2];
    assign rx_val   = regs[rx];
    assign ry_val   = regs[ry];
    assign imm8_z   = {8'h00, ir[7:0]};
    assign imm8_s   = {{8{ir[7]}}, ir[7:0]};
    assign imm5_s   = {{11{ir[4]}}, ir[4:0]};
    assign imm11_s  = {{5{ir[10]}}, ir[10:0]};
    assign pc_inc   = pc + 16'd1;          // wraps 0xFFFF -> 0x0000
    assign is_load  = (opcode == OP_LW);
    assign is_store = (opcode == OP_SW);

    // ---------------------------------------------------------------------
    // EXEC decode: register writeback and next PC. Encodings that match no
    // instruction leave wr_en and br_taken low, i.e. behave as NOP.
    // ---------------------------------------------------------------------
    logic        wr_en;
    logic [2:0]  wr_idx;
    logic [15:0] wr_val;
    logic        br_taken;
    logic [15:0] br_target;

    always_comb begin
        wr_en     = 1'b0;
        wr_idx    = rx;
        wr_val    = 16'h0000;
        br_taken  = 1'b0;
        br_target = pc_inc;
        case (opcode)
            OP_LI: begin
                wr_en  = 1'b1;
                wr_val = imm8_z;
            end
            OP_ADDIU: begin
                wr_en  = 1'b1;
                wr_val = rx_val + imm8_s;
            end
            OP_RRR: begin
                wr_idx = rz;
                if (ir[1:0] == 2'b01) begin
                    wr_en  = 1'b1;
                    wr_val = rx_val + ry_val;
                end else if (ir[1:0] == 2'b11) begin
                    wr_en  = 1'b1;
                    wr_val = rx_val - ry_val;
                end
            end
            OP_RR: begin
                if (ir[4:0] == 5'b01100) begin
                    wr_en  = 1'b1;
                    wr_val = rx_val & ry_val;
                end else if (ir[4:0] == 5'b01101) begin
                    wr_en  = 1'b1;
                    wr_val = rx_val | ry_val;
                end else if (ir[7:0] == 8'h00) begin
                    br_taken  = 1'b1;
                    br_target = rx_val;
                end
            end
            OP_B: begin
                br_taken  = 1'b1;
                br_target = pc_inc + imm11_s;
            end
            OP_BEQZ: begin
                br_taken  = (rx_val == 16'h0000);
                br_target = pc_inc + imm8_s;
            end
            OP_BNEZ: begin
                br_taken  = (rx_val != 16'h0000);
                br_target = pc_inc + imm8_s;
            end
            OP_NOP:  ;
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------
    // Bus strobes and next state. Everything is forced inactive while rst is
    // high so an instruction caught by reset cannot touch memory or the UART.
    // ---------------------------------------------------------------------
    logic        data_drive;
    logic [15:0] data_out;
    logic [15:0] load_val;

    always_comb begin
        state_nxt  = state;
        ram1_en    = 1'b1;
        ram1_oe    = 1'b1;
        ram1_we    = 1'b1;
        ram2_en    = 1'b1;
        ram2_oe    = 1'b1;
        rdn        = 1'b1;
        wrn        = 1'b1;
        ram1_addr  = 18'h00000;
        data_drive = 1'b0;
        data_out   = 16'h0000;
        load_val   = ram1_data;
        if (rst) begin
            state_nxt = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    ram2_en   = 1'b0;
                    ram2_oe   = 1'b0;
                    state_nxt = EXEC;
                end
                EXEC: begin
                    state_nxt = (is_load || is_store) ? MEM : FETCH;
                end
                MEM: begin
                    ram1_addr = {2'b00, mem_addr};
                    state_nxt = FETCH;
                    if (is_load) begin
                        if (mem_addr == UART_DATA) begin
                            rdn = 1'b0;
                        end else if (mem_addr == UART_STAT) begin
                            // Status is assembled locally; no strobe needed.
                            load_val = {14'b0, data_ready, tsre & tbre};
                        end else begin
                            ram1_en = 1'b0;
                            ram1_oe = 1'b0;
                        end
                    end else begin
                        if (mem_addr == UART_DATA) begin
                            wrn        = 1'b0;
                            data_drive = 1'b1;
                            data_out   = {8'h00, ry_val[7:0]};
                        end else if (mem_addr != UART_STAT) begin
                            ram1_en    = 1'b0;
                            ram1_we    = 1'b0;
                            data_drive = 1'b1;
                            data_out   = ry_val;
                        end
                    end
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

    assign ram1_data = data_drive ? data_out : 16'hzzzz;
    assign ram2_addr = {2'b00, pc};
    assign ram2_we   = 1'b1;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    // ---------------------------------------------------------------------
    // Architectural state: PC, IR, registers, latched data address
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= 16'h0000;
            ir       <= NOP_IR;
            mem_addr <= 16'h0000;
            for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
        end else begin
            case (state)
                FETCH: ir <= ram2_data;
                EXEC: begin
                    pc <= br_taken ? br_target : pc_inc;
                    if (wr_en) regs[wr_idx] <= wr_val;
                    if (is_load || is_store) mem_addr <= rx_val + imm5_s;
                end
                MEM: begin
                    if (is_load) regs[ry] <= load_val;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// ---------------------------------------------------------------------------
// tb_cpu_core -- scoreboard bench for cpu_core.
// An instruction-level model runs each program ahead of time and queues the
// bus events it implies (fetch address, RAM/UART accesses, and the cycle each
// happens in). A negedge monitor pops and compares whenever the core shows a
// strobe. Instruction and data memories are modelled around the core.
// ---------------------------------------------------------------------------
module tb_cpu_core;

    localparam int EV_FETCH = 0;
    localparam int EV_RAMWR = 1;
    localparam int EV_RAMRD = 2;
    localparam int EV_UWR   = 3;
    localparam int EV_URD   = 4;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [15:0] data;
        int          cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_50MHz = 1'b0;
    logic        clk_11MHz = 1'b0;
    wire  [15:0] ram1_data;
    wire  [15:0] ram2_data;
    logic [17:0] ram1_addr, ram2_addr;
    logic        ram1_en, ram1_oe, ram1_we;
    logic        ram2_en, ram2_oe, ram2_we;
    logic        tsre = 1'b1, tbre = 1'b1, data_ready = 1'b0;
    logic        rdn, wrn;

    logic [15:0] uart_rx = 16'h0000;
    logic [15:0] i_drv = 16'h0800;
    logic [15:0] r1_drv = 16'h0000;
    logic        r1_en_tb = 1'b0;

    logic [15:0] imem    [logic [15:0]];
    logic [15:0] tb_ram  [logic [15:0]];
    logic [15:0] mdl_mem [logic [15:0]];
    ev_t         exp_q   [$];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cpu_core dut (
        .clk(clk), .rst(rst), .clk_50MHz(clk_50MHz), .clk_11MHz(clk_11MHz),
        .ram1_data(ram1_data), .ram1_addr(ram1_addr),
        .ram1_en(ram1_en), .ram1_oe(ram1_oe), .ram1_we(ram1_we),
        .ram2_data(ram2_data), .ram2_addr(ram2_addr),
        .ram2_en(ram2_en), .ram2_oe(ram2_oe), .ram2_we(ram2_we),
        .tsre(tsre), .tbre(tbre), .data_ready(data_ready),
        .rdn(rdn), .wrn(wrn)
    );

    assign ram1_data = r1_en_tb ? r1_drv : 16'hzzzz;
    assign ram2_data = i_drv;

    // ---------------- memories around the core ----------------
    function automatic logic [15:0] ram_default(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    function automatic logic [15:0] imem_rd(input logic [15:0] a);
        return imem.exists(a) ? imem[a] : 16'h0800;
    endfunction

    function automatic logic [15:0] tbram_rd(input logic [15:0] a);
        return tb_ram.exists(a) ? tb_ram[a] : ram_default(a);
    endfunction

    always @(negedge clk) begin
        i_drv    = imem_rd(ram2_addr[15:0]);
        r1_en_tb = (!ram1_en && !ram1_oe) || !rdn;
        r1_drv   = !rdn ? uart_rx : tbram_rd(ram1_addr[15:0]);
    end

    always @(posedge clk) begin
        if (!ram1_en && !ram1_we) tb_ram[ram1_addr[15:0]] = ram1_data;
    end

    // ---------------- monitor ----------------
    int          cyc = 0;
    int          act;
    int          obs_kind;
    logic        obs_have;
    logic [17:0] obs_addr;
    logic [15:0] obs_data;
    ev_t         e;

    always @(negedge clk) begin
        if (rst) begin
            cyc = 0;
        end else begin
            act = int'(!ram1_en) + int'(!rdn) + int'(!wrn);
            if (act > 0) begin
                n_cmp++;
                if (act > 1) begin
                    n_fail++;
                    $display("FAIL strobe_exclusive active=%0d required=1 cyc=%0d", act, cyc);
                end
            end
            obs_have = 1'b1;
            obs_kind = EV_FETCH;
            obs_addr = 18'h0;
            obs_data = 16'h0;
            if (!ram2_en && !ram2_oe) begin
                obs_kind = EV_FETCH; obs_addr = ram2_addr;
            end else if (!ram1_en && !ram1_we) begin
                obs_kind = EV_RAMWR; obs_addr = ram1_addr; obs_data = ram1_data;
            end else if (!ram1_en && !ram1_oe) begin
                obs_kind = EV_RAMRD; obs_addr = ram1_addr;
            end else if (!wrn) begin
                obs_kind = EV_UWR; obs_data = ram1_data;
            end else if (!rdn) begin
                obs_kind = EV_URD;
            end else begin
                obs_have = 1'b0;
            end
            if (obs_have && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (e.kind != obs_kind || e.cyc != cyc || obs_addr != {2'b00, e.addr} ||
                    obs_data != e.data) begin
                    n_fail++;
                    $display("FAIL bus_event got kind=%0d addr=%h data=%h cyc=%0d required kind=%0d addr=%h data=%h cyc=%0d",
                             obs_kind, obs_addr, obs_data, cyc, e.kind, {2'b00, e.addr}, e.data, e.cyc);
                end
            end
            cyc++;
        end
    end

    // ---------------- instruction encoders ----------------
    function automatic logic [15:0] i_li(input logic [2:0] x, input logic [7:0] i);
        return {5'b01101, x, i};
    endfunction
    function automatic logic [15:0] i_addiu(input logic [2:0] x, input logic [7:0] i);
        return {5'b01001, x, i};
    endfunction
    function automatic logic [15:0] i_addu(input logic [2:0] x, y, z);
        return {5'b11100, x, y, z, 2'b01};
    endfunction
    function automatic logic [15:0] i_subu(input logic [2:0] x, y, z);
        return {5'b11100, x, y, z, 2'b11};
    endfunction
    function automatic logic [15:0] i_and(input logic [2:0] x, y);
        return {5'b11101, x, y, 5'b01100};
    endfunction
    function automatic logic [15:0] i_or(input logic [2:0] x, y);
        return {5'b11101, x, y, 5'b01101};
    endfunction
    function automatic logic [15:0] i_jr(input logic [2:0] x);
        return {5'b11101, x, 8'h00};
    endfunction
    function automatic logic [15:0] i_lw(input logic [2:0] x, y, input logic [4:0] i);
        return {5'b10011, x, y, i};
    endfunction
    function automatic logic [15:0] i_sw(input logic [2:0] x, y, input logic [4:0] i);
        return {5'b11011, x, y, i};
    endfunction
    function automatic logic [15:0] i_b(input logic [10:0] i);
        return {5'b00010, i};
    endfunction
    function automatic logic [15:0] i_beqz(input logic [2:0] x, input logic [7:0] i);
        return {5'b00100, x, i};
    endfunction
    function automatic logic [15:0] i_bnez(input logic [2:0] x, input logic [7:0] i);
        return {5'b00101, x, i};
    endfunction

    // ---------------- reference model ----------------
    function automatic void push_ev(input int k, input logic [15:0] a, input logic [15:0] d, input int c);
        ev_t ev;
        ev.kind = k; ev.addr = a; ev.data = d; ev.cyc = c;
        exp_q.push_back(ev);
    endfunction

    // Interprets `steps` instructions from PC 0 with all registers zero and
    // queues every bus event together with the cycle it should occur in.
    task automatic model_run(input int steps);
        logic [15:0] r [8];
        logic [15:0] pc, npc, w, a, v;
        logic [4:0]  op;
        logic [2:0]  x, y, z;
        int          c;
        for (int i = 0; i < 8; i++) r[i] = 16'h0;
        pc = 16'h0;
        c  = 0;
        for (int s = 0; s < steps; s++) begin
            w  = imem_rd(pc);
            push_ev(EV_FETCH, pc, 16'h0, c);
            op = w[15:11]; x = w[10:8]; y = w[7:5]; z = w[4:2];
            npc = pc + 16'd1;
            if (op == 5'b10011 || op == 5'b11011) begin
                a = r[x] + 16'($signed(w[4:0]));
                if (op == 5'b10011) begin
                    if (a == 16'hBF00) begin
                        push_ev(EV_URD, 16'h0, 16'h0, c + 2);
                        v = uart_rx;
                    end else if (a == 16'hBF01) begin
                        v = {14'b0, data_ready, tsre & tbre};
                    end else begin
                        push_ev(EV_RAMRD, a, 16'h0, c + 2);
                        v = mdl_mem.exists(a) ? mdl_mem[a] : ram_default(a);
                    end
                    r[y] = v;
                end else begin
                    if (a == 16'hBF00) push_ev(EV_UWR, 16'h0, {8'h00, r[y][7:0]}, c + 2);
                    else if (a != 16'hBF01) begin
                        push_ev(EV_RAMWR, a, r[y], c + 2);
                        mdl_mem[a] = r[y];
                    end
                end
                c += 3;
            end else begin
                case (op)
                    5'b01101: r[x] = {8'h00, w[7:0]};
                    5'b01001: r[x] = r[x] + 16'($signed(w[7:0]));
                    5'b11100: begin
                        if (w[1:0] == 2'b01) r[z] = r[x] + r[y];
                        else if (w[1:0] == 2'b11) r[z] = r[x] - r[y];
                    end
                    5'b11101: begin
                        if (w[4:0] == 5'b01100) r[x] = r[x] & r[y];
                        else if (w[4:0] == 5'b01101) r[x] = r[x] | r[y];
                        else if (w[7:0] == 8'h00) npc = r[x];
                    end
                    5'b00010: npc = pc + 16'd1 + 16'($signed(w[10:0]));
                    5'b00100: if (r[x] == 16'h0) npc = pc + 16'd1 + 16'($signed(w[7:0]));
                    5'b00101: if (r[x] != 16'h0) npc = pc + 16'd1 + 16'($signed(w[7:0]));
                    default: ;
                endcase
                c += 2;
            end
            pc = npc;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_env();
        imem.delete();
        tb_ram.delete();
        mdl_mem.delete();
    endtask

    task automatic put_data(input logic [15:0] a, input logic [15:0] v);
        tb_ram[a]  = v;
        mdl_mem[a] = v;
    endtask

    task automatic run_prog(input int steps);
        int guard;
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        model_run(steps);
        #1 rst = 1'b0;
        guard = 0;
        while (exp_q.size() > 0 && guard < steps * 3 + 40) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL run_timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        #1 rst = 1'b1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] w;
        logic [2:0]  x, y, z;
        logic [4:0]  i5;
        int          k, o;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_strobes", {25'h0, ram1_en, ram1_oe, ram1_we, ram2_en, ram2_oe, rdn, wrn}, 32'h7F);
        check("reset_ram1_addr", {14'h0, ram1_addr}, 32'h0);
        check("reset_ram2_we", {31'h0, ram2_we}, 32'h1);

        // LI R1,5 then expose R1 through a store
        clear_env();
        imem[16'd0] = i_li(3'd1, 8'h05);
        imem[16'd1] = i_sw(3'd0, 3'd1, 5'd0);
        run_prog(2);

        // ADDIU sign extension, SUBU, taken BEQZ skipping two words
        clear_env();
        imem[16'd0] = i_li(3'd1, 8'h7F);
        imem[16'd1] = i_addiu(3'd1, 8'h81);
        imem[16'd2] = i_subu(3'd1, 3'd1, 3'd2);
        imem[16'd3] = i_beqz(3'd2, 8'h02);
        imem[16'd4] = i_li(3'd6, 8'h11);
        imem[16'd5] = i_li(3'd6, 8'h22);
        imem[16'd6] = i_sw(3'd0, 3'd1, 5'd0);
        imem[16'd7] = i_sw(3'd0, 3'd2, 5'd1);
        imem[16'd8] = i_sw(3'd0, 3'd6, 5'd2);
        run_prog(7);

        // SW to 0x11 then LW back through RAM
        clear_env();
        imem[16'd0] = i_li(3'd3, 8'h10);
        imem[16'd1] = i_li(3'd4, 8'hAB);
        imem[16'd2] = i_sw(3'd3, 3'd4, 5'd1);
        imem[16'd3] = i_lw(3'd3, 3'd5, 5'd1);
        imem[16'd4] = i_sw(3'd0, 3'd5, 5'd2);
        run_prog(5);

        // UART status / data ports
        clear_env();
        tsre = 1'b1; tbre = 1'b1; data_ready = 1'b0; uart_rx = 16'h12C4;
        put_data(16'd5, 16'hBF00);
        imem[16'd0] = i_lw(3'd0, 3'd1, 5'd5);
        imem[16'd1] = i_lw(3'd1, 3'd2, 5'd1);
        imem[16'd2] = i_sw(3'd0, 3'd2, 5'd6);
        imem[16'd3] = i_sw(3'd1, 3'd2, 5'd0);
        imem[16'd4] = i_lw(3'd1, 3'd3, 5'd0);
        imem[16'd5] = i_sw(3'd0, 3'd3, 5'd7);
        imem[16'd6] = i_addu(3'd1, 3'd3, 3'd5);
        imem[16'd7] = i_sw(3'd1, 3'd5, 5'd0);
        imem[16'd8] = i_sw(3'd1, 3'd5, 5'd1);
        imem[16'd9] = i_and(3'd5, 3'd1);
        imem[16'd10] = i_sw(3'd0, 3'd5, 5'd8);
        run_prog(11);

        // JR to 0xFFFF, PC wraps to 0
        clear_env();
        imem[16'd0] = i_li(3'd1, 8'h00);
        imem[16'd1] = i_addiu(3'd1, 8'hFF);
        imem[16'd2] = i_jr(3'd1);
        run_prog(6);

        // Reset during the MEM cycle of a SW aborts the store
        clear_env();
        exp_q.delete();
        imem[16'd0] = i_li(3'd1, 8'h20);
        imem[16'd1] = i_sw(3'd1, 3'd1, 5'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort_mem_strobes", {30'h0, ram1_en, ram1_we}, 32'h3);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("refetch_addr", {14'h0, ram2_addr}, 32'h0);
        check("refetch_oe", {31'h0, ram2_oe}, 32'h0);
        check("abort_no_write", {31'h0, tb_ram.exists(16'h0020)}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Randomised programs
        for (int t = 0; t < 5; t++) begin
            clear_env();
            tsre = 1'($urandom); tbre = 1'($urandom); data_ready = 1'($urandom);
            uart_rx = 16'($urandom);
            put_data(16'd3, 16'hBF00);
            for (int a = 0; a < 32; a++) begin
                k  = $urandom_range(0, 14);
                x  = 3'($urandom_range(0, 7));
                y  = 3'($urandom_range(0, 7));
                z  = 3'($urandom_range(0, 7));
                i5 = 5'($urandom_range(0, 31));
                o  = $urandom_range(0, 10) - 4;
                w  = 16'($urandom);
                case (k)
                    0:  w = i_li(x, w[7:0]);
                    1:  w = i_addiu(x, w[7:0]);
                    2:  w = i_addu(x, y, z);
                    3:  w = i_subu(x, y, z);
                    4:  w = i_and(x, y);
                    5:  w = i_or(x, y);
                    6:  w = i_lw(x, y, i5);
                    7:  w = i_sw(x, y, i5);
                    8:  w = i_sw(3'd0, y, i5);
                    9:  w = i_beqz(x, o[7:0]);
                    10: w = i_bnez(x, o[7:0]);
                    11: w = i_b(o[10:0]);
                    12: w = i_jr(x);
                    13: w = i_lw(3'd0, y, 5'd3);
                    default: ;
                endcase
                imem[16'(a)] = w;
            end
            run_prog(48);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_core.md
CPU_CORE -- requirements
Module: cpu_core

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk and rst, sampled on the rising edge of clk.
REQ-002 clk  in  1  system clock; all state changes occur on its rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 clk_50MHz, clk_11MHz  in  1 each  accepted and ignored; no logic uses them.
REQ-005 ram1_data  inout  16  data memory and UART shared bus; high-Z unless writing.
REQ-006 ram1_addr  out  18  data memory word address.
REQ-007 ram1_en, ram1_oe, ram1_we  out  1 each  RAM1 chip enable, output enable and write enable; all active-low.
REQ-008 ram2_data  inout  16  instruction memory bus; always high-Z, read-only.
REQ-009 ram2_addr  out  18  instruction address: {2'b00, PC}.
REQ-010 ram2_en, ram2_oe, ram2_we  out  1 each  RAM2 strobes, active-low; ram2_we fixed at 1.
REQ-011 tsre, tbre, data_ready  in  1 each  UART status: transmit shift empty, transmit buffer empty, receive data ready.
REQ-012 rdn, wrn  out  1 each  UART read and write strobes, active-low.

Function
REQ-013 SHALL be a 16-bit multicycle core with 8 registers R0..R7, a 16-bit PC, and a 3-state FSM: FETCH, EXEC, MEM.
REQ-014 FETCH: drive ram2_en=0, ram2_oe=0, ram2_addr=PC; latch ram2_data into IR at the clock edge; go to EXEC.
REQ-015 EXEC: decode IR and set PC to PC+1 unless the instruction branches; ALU and branch instructions write results here and return to FETCH; LW and SW latch addr=rx+sext(imm5) and go to MEM.
REQ-016 MEM: perform one access in one cycle, write LW data back into ry, then return to FETCH. Non-memory instructions take 2 cycles; LW and SW take 3.
REQ-017 The opcode is IR[15:11]; rx=IR[10:8], ry=IR[7:5], rz=IR[4:2]. All arithmetic is 16-bit modulo 2^16.
REQ-018 Instructions:
- LI 01101: rx=zext(imm8).
- ADDIU 01001: rx+=sext(imm8).
- 11100, IR[1:0]=01: ADDU, rz=rx+ry.
- 11100, IR[1:0]=11: SUBU, rz=rx-ry.
- 11101, IR[4:0]=01100: AND, rx&=ry.
- 11101, IR[4:0]=01101: OR, rx|=ry.
- 11101, IR[7:0]=0: JR, PC=rx.
- LW 10011: ry=mem[rx+sext(imm5)].
- SW 11011: mem[rx+sext(imm5)]=ry.
- B 00010: PC=PC+1+sext(imm11).
- BEQZ 00100 / BNEZ 00101: if rx==0 / rx!=0, PC=PC+1+sext(imm8).
- NOP 00001.
- Any other encoding executes as NOP.
REQ-019 Data map for RAM1 addresses: 0xBF00 is UART data; 0xBF01 is UART status; all other addresses are RAM1 at {2'b00, addr}.
REQ-020 RAM read in MEM: ram1_en=0, ram1_oe=0, ram1_we=1; ram1_data is sampled at the clock edge.
REQ-021 RAM write in MEM: ram1_en=0, ram1_oe=1, ram1_we=0 for the full cycle; ram1_data is driven with ry.
REQ-022 UART data read: ram1_en=1, rdn=0 for the cycle; ram1_data is sampled into ry.
REQ-023 UART data write: ram1_en=1, wrn=0 for the cycle; ram1_data is driven with ry[7:0] zero-extended.
REQ-024 Status read returns {14'b0, data_ready, tsre&tbre}. No strobe is asserted. Writes to 0xBF01 are ignored.
REQ-025 Outside its access cycle, every active-low strobe is 1 and ram1_data is high-Z. Only one of RAM1, rdn or wrn is active in any cycle.
REQ-026 If the branch and PC+1 updates coincide, the branch target has priority. A PC overflow wraps 0xFFFF to 0x0000.

Reset
REQ-027 On rst=1 at a clock edge, the core SHALL:
- set PC=0, R0..R7=0, IR=NOP, state=FETCH;
- drive all en/oe/we/rdn/wrn outputs to 1 and ram1_addr=0;
- release both data buses to high-Z.
REQ-028 Reset asserted during EXEC or MEM SHALL abort the instruction; no register or memory write may occur in that cycle.
REQ-029 After rst deasserts, the first FETCH SHALL read address 0.

Verification
REQ-030 Reset pulse, RAM2[0]=LI R1,0x05 -> after 2 cycles R1=0x0005 and PC=1; ram2_addr steps 0 then 1.
REQ-031 Program LI R1,0x7F; ADDIU R1,0x81 (sext -127) -> R1=0x0000. Then SUBU R1,R1 to R2 -> R2=0x0000; BEQZ R2,+2 -> PC skips two words.
REQ-032 Program LI R3,0x10; LI R4,0xAB; SW R3,R4,1 -> in MEM: ram1_addr=0x00011, ram1_we=0, ram1_data=0x00AB. Then LW R3,R5,1 with the RAM returning 0x00AB -> R5=0x00AB.
REQ-033 Read from 0xBF01 with tsre=tbre=1 and data_ready=0 -> register=0x0001. A write to 0xBF00 -> wrn=0 for exactly one cycle and ram1_en=1.
REQ-034 Assert rst in the MEM cycle of an SW -> ram1_we stays 1 and the next fetch is from address 0.
